usb2_ep_in_writer: RTL and testbench

- Producer-side writer for the double-buffered USB 2.0 endpoint.
- Accepts a byte stream (valid/ready), e.g. transport-stream data, and writes it into the endpoint's current IN buffer through the buf_in_* interface.
- Commits a packet when the configured maximum length is reached, on an explicit flush, or after an idle timeout.
- Runs the commit/ack handshake and waits for the swapped buffer to become ready before writing the next packet.

---
 rtl/usb2_ep_in_writer_if.sv | 27 ++
 rtl/usb2_ep_in_writer.sv | 132 +++++++++++++
 tb/tb_usb2_ep_in_writer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb2_ep_in_writer_if.sv
// Stream-side and endpoint-buffer-side signals of the IN writer.
// master = writer; slave = stream source plus endpoint buffer.
interface usb2_ep_in_writer_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;

    logic [10:0] buf_in_addr;
    logic [7:0]  buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_ready;
    logic        buf_in_commit;
    logic [10:0] buf_in_commit_len;
    logic        buf_in_commit_ack;

    modport master (
        input  s_data, s_valid, buf_in_ready, buf_in_commit_ack,
        output s_ready, buf_in_addr, buf_in_data, buf_in_wren,
               buf_in_commit, buf_in_commit_len
    );

    modport slave (
        output s_data, s_valid, buf_in_ready, buf_in_commit_ack,
        input  s_ready, buf_in_addr, buf_in_data, buf_in_wren,
               buf_in_commit, buf_in_commit_len
    );
endinterface

// File: rtl/usb2_ep_in_writer.sv
// Producer-side writer for a double-buffered USB 2.0 IN endpoint: packs a byte
// stream into the current buffer half and commits it on full, flush or idle timeout.
module usb2_ep_in_writer #(
    parameter int unsigned MAX_LEN       = 512,
    parameter int unsigned FLUSH_TIMEOUT = 1024
) (
    input  logic                       phy_clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       flush,
    usb2_ep_in_writer_if.master        bus,
    output logic [15:0]                pkt_count,
    output logic                       busy
);

    localparam logic [10:0]       MAX_LEN_V = 11'(MAX_LEN);
    localparam int unsigned       IDLE_W    = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(FLUSH_TIMEOUT);

    typedef enum logic [2:0] {
        FILL,
        COMMIT_WAIT,
        COMMIT,
        ACK_LOW,
        GUARD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [10:0]       count;
    logic [10:0]       count_upd;
    logic [10:0]       len_r;
    logic [IDLE_W-1:0] idle;
    logic              accept;
    logic              timeout_hit;
    logic              latch_len;
    logic              clr_fill;
    logic              inc_pkt;

    // reset_n gates s_ready so it drops immediately on an asynchronous reset
    assign bus.s_ready = reset_n && (state == FILL) && enable && bus.buf_in_ready
                         && (count < MAX_LEN_V);
    assign accept      = bus.s_valid && bus.s_ready;
    assign count_upd   = count + 11'(accept);
    assign timeout_hit = (FLUSH_TIMEOUT != 0) && (idle == IDLE_MAX);

    assign bus.buf_in_commit_len = len_r;
    assign busy = (state != FILL) || (count != '0);

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        latch_len         = 1'b0;
        clr_fill          = 1'b0;
        inc_pkt           = 1'b0;
        bus.buf_in_commit = 1'b0;
        case (state)
            FILL: begin
                // decided on the updated count so a byte arriving with flush is included
                if ((count_upd == MAX_LEN_V) ||
                    ((count_upd != '0) && (flush || timeout_hit))) begin
                    state_next = COMMIT_WAIT;
                    latch_len  = 1'b1;
                end
            end
            COMMIT_WAIT: state_next = COMMIT;
            COMMIT: begin
                bus.buf_in_commit = 1'b1;
                if (bus.buf_in_commit_ack) begin
                    inc_pkt    = 1'b1;
                    state_next = ACK_LOW;
                end
            end
            ACK_LOW: begin
                if (!bus.buf_in_commit_ack) begin
                    state_next = GUARD;
                end
            end
            GUARD: begin
                clr_fill   = 1'b1;
                state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            count           <= '0;
            idle            <= '0;
            len_r           <= '0;
            pkt_count       <= '0;
            bus.buf_in_wren <= 1'b0;
            bus.buf_in_addr <= '0;
            bus.buf_in_data <= '0;
        end else begin
            bus.buf_in_wren <= accept;
            if (accept) begin
                bus.buf_in_addr <= count;
                bus.buf_in_data <= bus.s_data;
            end

            if (clr_fill) begin
                count <= '0;
            end else begin
                count <= count_upd;
            end

            if (clr_fill || accept || (count == '0)) begin
                idle <= '0;
            end else if ((state == FILL) && (idle != IDLE_MAX)) begin
                idle <= idle + 1'b1;
            end

            if (latch_len) begin
                len_r <= count_upd;
            end

            if (inc_pkt) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_usb2_ep_in_writer.sv
// Scoreboard bench for usb2_ep_in_writer: stimulus pushes expected writes/commits,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_usb2_ep_in_writer;

    localparam int unsigned MAX_LEN = 512;
    localparam int unsigned TO      = 16;

    logic        phy_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic        flush   = 1'b0;
    logic [15:0] pkt_count;
    logic        busy;

    usb2_ep_in_writer_if bus();

    usb2_ep_in_writer #(.MAX_LEN(MAX_LEN), .FLUSH_TIMEOUT(TO)) dut (
        .phy_clk   (phy_clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .flush     (flush),
        .bus       (bus),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    always #5 phy_clk = ~phy_clk;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
        longint      t;
    } wr_t;

    typedef struct {
        logic [10:0] len;
        longint      t;
    } cm_t;

    wr_t         wr_q[$];
    cm_t         cm_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned mc = 0;
    logic [15:0] exp_pkt = '0;
    int          ack_mode = 4;
    longint      last_accept = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    // monitor
    initial begin
        logic        prev;
        logic [10:0] cur_len;
        wr_t         w;
        cm_t         c;
        prev    = 1'b0;
        cur_len = '0;
        forever begin
            @(negedge phy_clk);
            if (reset_n) begin
                if (bus.buf_in_wren) begin
                    if (wr_q.size() == 0) begin
                        fail_now($sformatf("unexpected_wren addr=%0d", bus.buf_in_addr));
                    end else begin
                        w = wr_q.pop_front();
                        check("wr_addr", longint'(bus.buf_in_addr), longint'(w.addr));
                        check("wr_data", longint'(bus.buf_in_data), longint'(w.data));
                        check("wr_time", longint'($time), w.t);
                    end
                end
                if (bus.buf_in_commit && !prev) begin
                    if (cm_q.size() == 0) begin
                        fail_now($sformatf("unexpected_commit len=%0d", bus.buf_in_commit_len));
                    end else begin
                        c = cm_q.pop_front();
                        check("commit_len", longint'(bus.buf_in_commit_len), longint'(c.len));
                        if (c.t != 0) check("commit_time", longint'($time), c.t);
                    end
                    cur_len = bus.buf_in_commit_len;
                end
                if (bus.buf_in_commit && prev)
                    check("commit_len_stable", longint'(bus.buf_in_commit_len), longint'(cur_len));
                if (!bus.buf_in_commit && prev) begin
                    exp_pkt = exp_pkt + 16'd1;
                    check("pkt_count", longint'(pkt_count), longint'(exp_pkt));
                end
                prev = bus.buf_in_commit;
            end else begin
                prev = 1'b0;
            end
        end
    end

    // endpoint ack model
    initial begin
        bus.buf_in_commit_ack = 1'b0;
        forever begin
            @(negedge phy_clk);
            if (reset_n && bus.buf_in_commit && ack_mode != 0) begin
                bus.buf_in_commit_ack = 1'b1;
                @(negedge phy_clk);
                check("commit_drop_after_ack", longint'(bus.buf_in_commit), 0);
                for (int k = 1; k < ack_mode; k++) @(negedge phy_clk);
                bus.buf_in_commit_ack = 1'b0;
            end
        end
    end

    // call at a negedge; returns at a negedge after the byte was accepted
    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        #1;
        while (!bus.s_ready) begin
            @(negedge phy_clk);
            #1;
            n++;
            if (n > 2000) begin
                fail_now("send_timeout");
                bus.s_valid = 1'b0;
                return;
            end
        end
        @(posedge phy_clk);
        last_accept = longint'($time);
        wr_q.push_back('{addr: 11'(mc), data: d, t: last_accept + 5});
        mc++;
        if (mc == MAX_LEN) begin
            cm_q.push_back('{len: 11'(MAX_LEN), t: last_accept + 15});
            mc = 0;
        end
        @(negedge phy_clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic expect_commit(input int unsigned len);
        cm_q.push_back('{len: 11'(len), t: 0});
        mc = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge phy_clk);
            n++;
        end while ((busy || cm_q.size() != 0) && n < 3000);
        if (n >= 3000) fail_now("wait_done_timeout");
    endtask

    initial begin
        bus.s_data       = '0;
        bus.s_valid      = 1'b0;
        bus.buf_in_ready = 1'b1;
        enable           = 1'b1;
        repeat (3) @(negedge phy_clk);
        check("rst_commit", longint'(bus.buf_in_commit), 0);
        check("rst_wren", longint'(bus.buf_in_wren), 0);
        check("rst_s_ready", longint'(bus.s_ready), 0);
        check("rst_pkt_count", longint'(pkt_count), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_addr", longint'(bus.buf_in_addr), 0);
        reset_n = 1'b1;
        @(negedge phy_clk);

        // full packet, continuous bytes, 4-cycle ack
        for (int i = 0; i < 512; i++) send(8'(i));
        wait_done();
        check("pkt_after_full", longint'(pkt_count), 1);

        // 37 bytes then flush held with no further data
        for (int i = 0; i < 37; i++) send(8'(i * 3 + 1));
        flush = 1'b1;
        expect_commit(37);
        repeat (40) @(negedge phy_clk);
        flush = 1'b0;
        wait_done();
        check("pkt_after_flush", longint'(pkt_count), 2);

        // idle timeout: commit appears after 16 idle cycles
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i));
        cm_q.push_back('{len: 11'd5, t: last_accept + 185});
        mc = 0;
        wait_done();

        // both buffers full: nothing accepted, then resume at addr 0
        bus.buf_in_ready = 1'b0;
        bus.s_data       = 8'h5A;
        bus.s_valid      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("s_ready_buf_full", longint'(bus.s_ready), 0);
            @(negedge phy_clk);
        end
        check("busy_buf_full", longint'(busy), 0);
        bus.buf_in_ready = 1'b1;
        send(8'h5A);
        send(8'h5B);
        send(8'h5C);
        flush = 1'b1;
        expect_commit(3);
        @(negedge phy_clk);
        flush = 1'b0;
        wait_done();

        // enable low mid-packet: data retained, flush commits it
        for (int i = 0; i < 10; i++) send(8'hC0 + 8'(i));
        enable      = 1'b0;
        bus.s_data  = 8'hEE;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("s_ready_disabled", longint'(bus.s_ready), 0);
            @(negedge phy_clk);
        end
        bus.s_valid = 1'b0;
        flush = 1'b1;
        expect_commit(10);
        @(negedge phy_clk);
        flush  = 1'b0;
        wait_done();
        enable = 1'b1;

        // fast-commit single-cycle ack, next packet starts at addr 0
        ack_mode = 1;
        for (int i = 0; i < 20; i++) send(8'h10 + 8'(i));
        flush = 1'b1;
        expect_commit(20);
        @(negedge phy_clk);
        flush = 1'b0;
        wait_done();
        for (int i = 0; i < 4; i++) send(8'h77 + 8'(i));
        flush = 1'b1;
        expect_commit(4);
        @(negedge phy_clk);
        flush = 1'b0;
        wait_done();
        check("pkt_after_fast", longint'(pkt_count), 7);
        ack_mode = 4;

        // last byte of a full packet together with flush: exactly one commit
        for (int i = 0; i < 511; i++) send(8'(255 - i));
        flush = 1'b1;
        send(8'h42);
        repeat (10) @(negedge phy_clk);
        flush = 1'b0;
        wait_done();
        check("pkt_after_max_flush", longint'(pkt_count), 8);

        // reset during COMMIT
        ack_mode = 0;
        for (int i = 0; i < 20; i++) send(8'(i));
        flush = 1'b1;
        expect_commit(20);
        @(negedge phy_clk);
        flush = 1'b0;
        begin
            int n;
            n = 0;
            while (!bus.buf_in_commit && n < 50) begin
                @(negedge phy_clk);
                n++;
            end
            if (n >= 50) fail_now("commit_wait_timeout");
        end
        @(negedge phy_clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_commit", longint'(bus.buf_in_commit), 0);
        check("arst_wren", longint'(bus.buf_in_wren), 0);
        check("arst_s_ready", longint'(bus.s_ready), 0);
        check("arst_pkt_count", longint'(pkt_count), 0);
        check("arst_busy", longint'(busy), 0);
        repeat (3) @(negedge phy_clk);
        exp_pkt  = '0;
        mc       = 0;
        ack_mode = 4;
        reset_n  = 1'b1;
        @(negedge phy_clk);
        for (int i = 0; i < 512; i++) send(8'(i + 7));
        wait_done();
        check("pkt_after_reset", longint'(pkt_count), 1);

        repeat (5) @(negedge phy_clk);
        check("wr_queue_empty", longint'(wr_q.size()), 0);
        check("commit_queue_empty", longint'(cm_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
